// File: rtl/uart_rcv_block.sv
// uart_rcv_block: oversampling serial receiver (1 start, NUM_DATA_BITS LSB-first, 1 stop).
// Ports:
//   clk, n_rst     - system clock, asynchronous active-low reset
//   serial_in      - asynchronous serial line, idle high
//   data_read      - consumer pulse: rx_data has been taken
//   rx_data        - last good received word (registered)
//   data_ready     - rx_data holds an unread word (registered)
//   overrun_error  - a word was overwritten before being read (registered)
//   framing_error  - last frame had a stop bit of 0 (registered)
module uart_rcv_block #(
  parameter int unsigned NUM_DATA_BITS = 8,
  parameter int unsigned CLKS_PER_BIT  = 10
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     serial_in,
  input  logic                     data_read,
  output logic [NUM_DATA_BITS-1:0] rx_data,
  output logic                     data_ready,
  output logic                     overrun_error,
  output logic                     framing_error
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(NUM_DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
    STOP,
    LOAD
  } state_t;

  state_t state, state_nxt;

  logic                     sync1, sync2, sync_d;
  logic [TW-1:0]            timer;
  logic [BW-1:0]            bit_cnt;
  logic [NUM_DATA_BITS-1:0] shift_reg;
  logic                     stop_bit;
  logic                     start_c, sample_c, load_c;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync1  <= serial_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control strobes
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    sample_c  = 1'b0;
    load_c    = 1'b0;
    case (state)
      IDLE: begin
        if (sync_d && !sync2) begin
          start_c   = 1'b1;
          state_nxt = START_CHK;
        end
      end
      START_CHK: begin
        // Mid start bit: a high line here means the edge was a glitch
        if (timer == HALF_LAST) begin
          sample_c  = 1'b1;
          state_nxt = sync2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == FULL_LAST) begin
          sample_c = 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = STOP;
        end
      end
      STOP: begin
        if (timer == FULL_LAST) begin
          sample_c  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing, bit counter and serial-to-parallel capture
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer     <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      stop_bit  <= 1'b0;
    end else begin
      if (state == IDLE || sample_c) timer <= '0;
      else                           timer <= timer + TW'(1);

      if (state == START_CHK)            bit_cnt <= '0;
      else if (state == DATA && sample_c) bit_cnt <= bit_cnt + BW'(1);

      // Entering from the MSB end leaves bit 0 in position 0 after the last shift
      if (state == DATA && sample_c)
        shift_reg <= {sync2, shift_reg[NUM_DATA_BITS-1:1]};

      if (state == STOP && sample_c) stop_bit <= sync2;
    end
  end

  // Holding register and status flags; a good load takes priority over data_read
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '1;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (start_c) framing_error <= 1'b0;

      if (load_c && stop_bit) begin
        rx_data    <= shift_reg;
        data_ready <= 1'b1;
        if (data_ready && !data_read) overrun_error <= 1'b1;
      end else begin
        if (load_c) framing_error <= 1'b1;
        if (data_read) begin
          data_ready    <= 1'b0;
          overrun_error <= 1'b0;
        end
      end
    end
  end

endmodule
